// File: rtl/sram_ctrl_pkg.sv
// Purpose: shared encodings and helpers for the async SRAM controller.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package sram_ctrl_pkg;

    // State encodings. S_TURN only has a role when SRAM_TURNAROUND_EN is defined.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_TURN   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_ACCESS = S_ACCESS,
        ST_HOLD   = S_HOLD,
        ST_TURN   = S_TURN
    } state_t;

    // Wide enough for WAIT_CYC up to 15.
    localparam int WCNT_W = 4;

    // Expands one byte-enable bit into an 8-bit lane mask.
    function automatic logic [7:0] lane_mask(input logic en);
        return {8{en}};
    endfunction

endpackage

// File: rtl/sram_dq_io.sv
// Purpose: SRAM data-pin tri-state driver and registered read-data capture.
// Latency: drive/out data and rd_data update one clock after their enables.
// Backpressure: none; purely slaved to the controller FSM.
//
// Ports: clk/rst_n; drive_d (next drive flag), wdata_ld/wdata (load write
// data), cap_en/cap_mask (capture dq into rd_data with byte masking),
// rd_data (captured read data), dq (SRAM data pins).
module sram_dq_io #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          drive_d,
    input  logic          wdata_ld,
    input  logic [DW-1:0] wdata,
    input  logic          cap_en,
    input  logic [DW-1:0] cap_mask,
    output logic [DW-1:0] rd_data,
    inout  wire  [DW-1:0] dq
);

    logic          drive;
    logic [DW-1:0] out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive   <= 1'b0;
            out_q   <= '0;
            rd_data <= '0;
        end else begin
            drive <= drive_d;
            if (wdata_ld) out_q <= wdata;
            if (cap_en) rd_data <= dq & cap_mask;
        end
    end

    // The drive flag is a register, so the bus is released immediately on reset.
    assign dq = drive ? out_q : {DW{1'bz}};

endmodule

// File: rtl/sram_ctrl.sv
// Purpose: valid/ready front end that turns each request into one timed async SRAM access.
// Latency: accept at edge 0 -> strobe active cycles 1..WAIT_CYC, rd_valid in cycle WAIT_CYC+1.
// Backpressure: req_ready only in IDLE; one access per WAIT_CYC+2 cycles (+1 after writes with turnaround).
//
// Ports: clk, rst_n; request side req_valid/req_ready/req_we/req_addr/req_wdata/req_be;
// read return rd_valid/rd_data; busy; SRAM pins sram_addr/sram_dq/sram_ce_n/
// sram_oe_n/sram_we_n/sram_be_n. All pin outputs are registered.
// Optional macro SRAM_TURNAROUND_EN: adds a one-cycle chip-deselect TURN state after writes.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 18,
    parameter int WAIT_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_be,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic            busy,
    output logic [AW-1:0]   sram_addr,
    inout  wire  [DW-1:0]   sram_dq,
    output logic            sram_ce_n,
    output logic            sram_oe_n,
    output logic            sram_we_n,
    output logic [DW/8-1:0] sram_be_n
);

    localparam int BW = DW / 8;

    state_t            state, state_d;
    logic [WCNT_W-1:0] cnt, cnt_d;
    logic              we_q, we_d;
    logic [BW-1:0]     be_q, be_d;
    logic              accept;
    logic              cap_en;
    logic              rd_valid_d;
    logic              ce_n_d, oe_n_d, we_n_d, drive_d;
    logic [BW-1:0]     be_n_d;
    logic [DW-1:0]     cap_mask;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= '1;
            rd_valid  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            we_q      <= we_d;
            be_q      <= be_d;
            if (accept) sram_addr <= req_addr;
            sram_ce_n <= ce_n_d;
            sram_oe_n <= oe_n_d;
            sram_we_n <= we_n_d;
            sram_be_n <= be_n_d;
            rd_valid  <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        we_d       = we_q;
        be_d       = be_q;
        cap_en     = 1'b0;
        rd_valid_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACCESS;
                    cnt_d   = WCNT_W'(WAIT_CYC - 1);
                    we_d    = req_we;
                    be_d    = req_be;
                end
            end
            ST_ACCESS: begin
                if (cnt == '0) begin
                    state_d    = ST_HOLD;
                    cap_en     = !we_q;
                    rd_valid_d = !we_q;
                end else begin
                    cnt_d = cnt - WCNT_W'(1);
                end
            end
            ST_HOLD: begin
`ifdef SRAM_TURNAROUND_EN
                state_d = we_q ? ST_TURN : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef SRAM_TURNAROUND_EN
            ST_TURN: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase

        // Pins are a function of the state being entered, so each pin flop
        // already shows the new state's levels in the first cycle of that state.
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = '1;
        drive_d = 1'b0;
        case (state_d)
            ST_ACCESS: begin
                ce_n_d  = 1'b0;
                oe_n_d  = we_d;
                // A write with no lanes enabled is timed but never strobes WE.
                we_n_d  = !(we_d && (|be_d));
                be_n_d  = ~be_d;
                drive_d = we_d;
            end
            ST_HOLD: begin
                ce_n_d  = 1'b0;
                be_n_d  = ~be_d;
                drive_d = we_d;
            end
            default: ;
        endcase
    end

    always_comb begin
        cap_mask = '0;
        for (int i = 0; i < BW; i++) begin
            cap_mask[i*8 +: 8] = lane_mask(be_q[i]);
        end
    end

    sram_dq_io #(.DW(DW)) u_dq (
        .clk      (clk),
        .rst_n    (rst_n),
        .drive_d  (drive_d),
        .wdata_ld (accept),
        .wdata    (req_wdata),
        .cap_en   (cap_en),
        .cap_mask (cap_mask),
        .rd_data  (rd_data),
        .dq       (sram_dq)
    );

endmodule

// File: tb/tb_sram_ctrl.sv
// Purpose: self-checking bench for sram_ctrl with a behavioural async SRAM model (tAA-limited reads).
// Latency: checks strobe widths, rd_valid position and accept spacing against WAIT_CYC.
// Backpressure: request driver waits on req_ready with a bounded cycle budget.
module tb_sram_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 18;
    localparam int BW  = DW / 8;
    localparam int WC  = 2;
    localparam int TAA = 2;
    localparam int RD_GAP = WC + 2;
`ifdef SRAM_TURNAROUND_EN
    localparam int WR_GAP = WC + 3;
`else
    localparam int WR_GAP = WC + 2;
`endif

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_dq;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [BW-1:0] sram_be_n;

    sram_ctrl #(.DW(DW), .AW(AW), .WAIT_CYC(WC)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_be_n (sram_be_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- behavioural SRAM model ----------------
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] model_q = 16'hDEAD;
    logic [DW-1:0] wtmp;
    int            oe_cnt = 0;
    wire           model_en = !sram_ce_n && !sram_oe_n && sram_we_n;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    assign sram_dq = model_en ? model_q : {DW{1'bz}};

    // Read data only becomes valid once OE/CE have been low for TAA cycles;
    // before that the model returns a poison pattern.
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            wtmp = mem_rd(sram_addr);
            for (int b = 0; b < BW; b++)
                if (!sram_be_n[b]) wtmp[b*8 +: 8] = sram_dq[b*8 +: 8];
            mem[sram_addr] = wtmp;
        end
        if (model_en) oe_cnt++;
        else oe_cnt = 0;
        model_q = (oe_cnt >= TAA) ? mem_rd(sram_addr) : 16'hDEAD;
        if (!sram_oe_n && !sram_we_n) begin
            n_chk++;
            $display("FAIL bus_conflict: oe_n=%0b we_n=%0b, required not both low", sram_oe_n, sram_we_n);
        end
    end

    // ---------------- read scoreboard ----------------
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] sb_e;
    int            rv_total = 0;

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            rv_total++;
            if (exp_q.size() == 0) begin
                chk("rd_valid_unexpected", 32'd1, 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(sb_e));
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vt [12];

    task automatic wait_ready(input string nm);
        int w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk(nm, 32'(req_ready), 32'd1);
    endtask

    task automatic run_txn(input vec_t v);
        int we_lo = 0, oe_lo = 0, rv_cnt = 0, rv_at = 0, drv_seen = 0;
        logic [DW-1:0] hold_dq = '0;
        logic hold_ce = 1'b1, rdy_end = 1'b0;
        wait_ready("ready_timeout");
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
        if (!v.we) exp_q.push_back(v.exp);
        @(posedge clk);
        for (int k = 1; k <= WC + 2; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            we_lo += int'(!sram_we_n);
            oe_lo += int'(!sram_oe_n);
            if (rd_valid) begin
                rv_cnt++;
                rv_at = k;
            end
            if (u_dut.u_dq.drive) drv_seen++;
            if (k == WC + 1) begin
                hold_dq = sram_dq;
                hold_ce = sram_ce_n;
            end
            if (k == WC + 2) rdy_end = req_ready;
        end
        chk("we_n_low_cycles", 32'(we_lo), (v.we && v.be != '0) ? WC : 0);
        chk("oe_n_low_cycles", 32'(oe_lo), v.we ? 0 : WC);
        chk("hold_ce_n", 32'(hold_ce), 32'd0);
        if (!v.we) begin
            chk("rd_valid_pulses", 32'(rv_cnt), 32'd1);
            chk("rd_valid_cycle", 32'(rv_at), WC + 1);
            chk("read_dq_driven_cycles", 32'(drv_seen), 32'd0);
            chk("ready_after_read", 32'(rdy_end), 32'd1);
        end else begin
            chk("write_rd_valid", 32'(rv_cnt), 32'd0);
            chk("hold_dq", 32'(hold_dq), 32'(v.wdata));
            chk("ready_after_write", 32'(rdy_end), (WR_GAP == RD_GAP) ? 1 : 0);
        end
    endtask

    task automatic b2b_fields(input int k);
        req_we    = (k % 2 == 0);
        req_addr  = AW'(18'h40 + k / 2);
        req_wdata = DW'(16'hC000 + k);
        req_be    = 2'b11;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc [6];
        int cyc, n, rv_before;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;

        vt[0]  = '{1'b1, 18'h00012, 16'hA55A, 2'b11, 16'h0000};
        vt[1]  = '{1'b0, 18'h00012, 16'h0000, 2'b11, 16'hA55A};
        vt[2]  = '{1'b1, 18'h00012, 16'h1234, 2'b01, 16'h0000};
        vt[3]  = '{1'b0, 18'h00012, 16'h0000, 2'b11, 16'hA534};
        vt[4]  = '{1'b0, 18'h00012, 16'h0000, 2'b10, 16'hA500};
        vt[5]  = '{1'b0, 18'h00012, 16'h0000, 2'b01, 16'h0034};
        vt[6]  = '{1'b1, 18'h3FFFF, 16'hFFFF, 2'b11, 16'h0000};
        vt[7]  = '{1'b0, 18'h3FFFF, 16'h0000, 2'b11, 16'hFFFF};
        vt[8]  = '{1'b1, 18'h00000, 16'hBE01, 2'b10, 16'h0000};
        vt[9]  = '{1'b0, 18'h00000, 16'h0000, 2'b11, 16'hBE00};
        vt[10] = '{1'b1, 18'h00012, 16'hFFFF, 2'b00, 16'h0000};
        vt[11] = '{1'b0, 18'h00012, 16'h0000, 2'b11, 16'hA534};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_be_n", 32'(sram_be_n), 32'd3);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_drive", 32'(u_dut.u_dq.drive), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Reset in the middle of a write
        req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h00100;
        req_wdata = 16'h5A5A; req_be = 2'b11;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("midwr_we_n_active", 32'(sram_we_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midwr_rst_ce_n", 32'(sram_ce_n), 32'd1);
        chk("midwr_rst_we_n", 32'(sram_we_n), 32'd1);
        chk("midwr_rst_drive", 32'(u_dut.u_dq.drive), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a read: no rd_valid may follow
        rv_before = rv_total;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h00012; req_be = 2'b11;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrd_oe_n_active", 32'(sram_oe_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrd_rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("midrd_rst_ce_n", 32'(sram_ce_n), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrd_no_rd_valid", 32'(rv_total - rv_before), 32'd0);

        // Table-driven accesses
        for (int i = 0; i < 12; i++) begin
            run_txn(vt[i]);
            if (i == 0) chk("model_after_write", 32'(mem_rd(18'h00012)), 32'h0000A55A);
            if (i == 10) begin
                chk("model_be0_unchanged", 32'(mem_rd(18'h00012)), 32'h0000A534);
                chk("rd_data_hold", 32'(rd_data), 32'h0000BE00);
            end
        end

        // Back-to-back alternating write/read with req_valid held high
        wait_ready("b2b_start_ready");
        b2b_fields(0);
        req_valid = 1'b1;
        cyc = 0;
        n = 0;
        while (n < 6 && cyc < 200) begin
            if (req_ready) begin
                acc[n] = cyc;
                if (!req_we) exp_q.push_back(DW'(16'hC000 + n - 1));
                n++;
                @(negedge clk);
                cyc++;
                if (n < 6) b2b_fields(n);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(n), 32'd6);
        for (int i = 1; i < 6; i++)
            chk("b2b_gap", 32'(acc[i] - acc[i-1]), ((i - 1) % 2 == 0) ? WR_GAP : RD_GAP);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("final_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
